// File: rtl/t_counter.sv
// ----------------------------------------------------------------------------
// t_counter
// Parametrised modulo-N up/down counter built from per-bit toggle registers.
// All state changes happen on the falling edge of CLK; RST clears state
// asynchronously.  Update priority at each edge: RST > LD > EN > hold.
//
// Parameters
//   WIDTH    counter width in bits (1..16)
//   MODULUS  count modulus, Q runs 0..MODULUS-1 (2..2**WIDTH)
//
// Ports
//   CLK   in   clock, falling-edge active
//   RST   in   asynchronous reset, active-high
//   EN    in   count enable
//   UP    in   direction: 1 = increment, 0 = decrement
//   LD    in   synchronous parallel load (clamped to MODULUS-1)
//   D     in   load value
//   Q     out  registered count
//   Qbar  out  bitwise complement of Q
//   TC    out  registered terminal-count pulse, high for one period after a wrap
//   TGL   out  toggle vector the next falling edge will apply to Q
//   G     out  registered Gray code of Q (only with T_COUNTER_GRAY_OUT_EN)
//
// Optional feature macro: T_COUNTER_GRAY_OUT_EN adds the G output.
// ----------------------------------------------------------------------------
module t_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             UP,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             TC,
   output logic [WIDTH-1:0] TGL
`ifdef T_COUNTER_GRAY_OUT_EN
   ,
   output logic [WIDTH-1:0] G
`endif
);

   // Reject illegal configurations at elaboration time.
   if ((WIDTH < 1) || (WIDTH > 16)) begin : g_bad_width
      $error("t_counter: WIDTH=%0d outside 1..16", WIDTH);
   end
   if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
      $error("t_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
   end

   // One extra bit so MODULUS = 2**WIDTH is representable in the load compare.
   localparam logic [WIDTH:0]   MOD_V  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             tc_q;
   logic             tc_d;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap;
   logic [WIDTH-1:0] tgl;

   // Next count value and wrap detection; wrap is decided by compare against
   // MAX_V / zero, never by natural overflow of the adder.
   always_comb begin
      q_nxt = q_q;
      wrap  = 1'b0;
      if (LD) begin
         if ({1'b0, D} < MOD_V) begin
            q_nxt = D;
         end else begin
            q_nxt = MAX_V;
         end
      end else if (EN) begin
         if (UP) begin
            if (q_q == MAX_V) begin
               q_nxt = ZERO_V;
               wrap  = 1'b1;
            end else begin
               q_nxt = q_q + ONE_V;
            end
         end else begin
            if (q_q == ZERO_V) begin
               q_nxt = MAX_V;
               wrap  = 1'b1;
            end else begin
               q_nxt = q_q - ONE_V;
            end
         end
      end else begin
         q_nxt = q_q;
         wrap  = 1'b0;
      end
   end

   // Toggle vector and register inputs; toggles are suppressed while in reset.
   always_comb begin
      tgl  = ZERO_V;
      tc_d = 1'b0;
      if (RST) begin
         tgl  = ZERO_V;
         tc_d = 1'b0;
      end else begin
         tgl  = q_q ^ q_nxt;
         tc_d = wrap;
      end
      q_d = q_q ^ tgl;
   end

   // Per-bit toggle registers for the count plus the terminal-count flop.
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         q_q  <= ZERO_V;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
      end
   end

   assign Q    = q_q;
   assign Qbar = ~q_q;
   assign TC   = tc_q;
   assign TGL  = tgl;

`ifdef T_COUNTER_GRAY_OUT_EN
   logic [WIDTH-1:0] g_q;
   logic [WIDTH-1:0] g_d;

   // Gray encoding of the value Q is about to take.
   always_comb begin
      g_d = q_d ^ (q_d >> 1);
   end

   // Gray output register, captured on the same edge as Q.
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         g_q <= ZERO_V;
      end else begin
         g_q <= g_d;
      end
   end

   assign G = g_q;
`endif

endmodule

// File: tb/tb_t_counter.sv
// ----------------------------------------------------------------------------
// tb_t_counter
// Self-checking bench for t_counter.  Three instances:
//   a: WIDTH=4, MODULUS=10   b: WIDTH=3, MODULUS=2   c: WIDTH=4, MODULUS=16
// An arithmetic model per instance is compared against every output on each
// rising CLK edge (mid-period); directed sequences add literal expectations.
// ----------------------------------------------------------------------------
module tb_t_counter;

   logic clk = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       rst_a, en_a, up_a, ld_a;
   logic [3:0] d_a;
   logic [3:0] q_a, qb_a, tgl_a;
   logic       tc_a;

   logic       rst_b, en_b, up_b, ld_b;
   logic [2:0] d_b;
   logic [2:0] q_b, qb_b, tgl_b;
   logic       tc_b;

   logic       rst_c, en_c, up_c, ld_c;
   logic [3:0] d_c;
   logic [3:0] q_c, qb_c, tgl_c;
   logic       tc_c;
`ifdef T_COUNTER_GRAY_OUT_EN
   logic [3:0] g_c;
`endif

   t_counter #(.WIDTH(4), .MODULUS(10)) u_a (
      .CLK(clk), .RST(rst_a), .EN(en_a), .UP(up_a), .LD(ld_a), .D(d_a),
      .Q(q_a), .Qbar(qb_a), .TC(tc_a), .TGL(tgl_a));

   t_counter #(.WIDTH(3), .MODULUS(2)) u_b (
      .CLK(clk), .RST(rst_b), .EN(en_b), .UP(up_b), .LD(ld_b), .D(d_b),
      .Q(q_b), .Qbar(qb_b), .TC(tc_b), .TGL(tgl_b));

   t_counter #(.WIDTH(4), .MODULUS(16)) u_c (
      .CLK(clk), .RST(rst_c), .EN(en_c), .UP(up_c), .LD(ld_c), .D(d_c),
      .Q(q_c), .Qbar(qb_c), .TC(tc_c), .TGL(tgl_c)
`ifdef T_COUNTER_GRAY_OUT_EN
      , .G(g_c)
`endif
   );

   // ---------------- model ----------------
   function automatic int nxt(input int q, input bit ld, input bit en,
                              input bit up, input int d, input int m);
      if (ld) return (d < m) ? d : m - 1;
      if (en) return up ? (q + 1) % m : (q + m - 1) % m;
      return q;
   endfunction

   function automatic bit wrp(input int q, input bit ld, input bit en,
                              input bit up, input int m);
      return !ld && en && (up ? (q == m - 1) : (q == 0));
   endfunction

   int mq_a = 0, mq_b = 0, mq_c = 0;
   bit mtc_a = 1'b0, mtc_b = 1'b0, mtc_c = 1'b0;

   always @(negedge clk or posedge rst_a) begin
      if (rst_a) begin
         mq_a <= 0; mtc_a <= 1'b0;
      end else begin
         mq_a  <= nxt(mq_a, ld_a, en_a, up_a, int'(d_a), 10);
         mtc_a <= wrp(mq_a, ld_a, en_a, up_a, 10);
      end
   end

   always @(negedge clk or posedge rst_b) begin
      if (rst_b) begin
         mq_b <= 0; mtc_b <= 1'b0;
      end else begin
         mq_b  <= nxt(mq_b, ld_b, en_b, up_b, int'(d_b), 2);
         mtc_b <= wrp(mq_b, ld_b, en_b, up_b, 2);
      end
   end

   always @(negedge clk or posedge rst_c) begin
      if (rst_c) begin
         mq_c <= 0; mtc_c <= 1'b0;
      end else begin
         mq_c  <= nxt(mq_c, ld_c, en_c, up_c, int'(d_c), 16);
         mtc_c <= wrp(mq_c, ld_c, en_c, up_c, 16);
      end
   end

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
      end
   endtask

   // Continuous compare, mid-period.
   always @(posedge clk) begin
      chk("a_q",    int'(q_a),   mq_a);
      chk("a_qbar", int'(qb_a),  mq_a ^ 15);
      chk("a_tc",   int'(tc_a),  int'(mtc_a));
      chk("a_tgl",  int'(tgl_a), rst_a ? 0 : (mq_a ^ nxt(mq_a, ld_a, en_a, up_a, int'(d_a), 10)));
      chk("b_q",    int'(q_b),   mq_b);
      chk("b_qbar", int'(qb_b),  mq_b ^ 7);
      chk("b_tc",   int'(tc_b),  int'(mtc_b));
      chk("b_tgl",  int'(tgl_b), rst_b ? 0 : (mq_b ^ nxt(mq_b, ld_b, en_b, up_b, int'(d_b), 2)));
      chk("c_q",    int'(q_c),   mq_c);
      chk("c_qbar", int'(qb_c),  mq_c ^ 15);
      chk("c_tc",   int'(tc_c),  int'(mtc_c));
      chk("c_tgl",  int'(tgl_c), rst_c ? 0 : (mq_c ^ nxt(mq_c, ld_c, en_c, up_c, int'(d_c), 16)));
`ifdef T_COUNTER_GRAY_OUT_EN
      chk("c_g",    int'(g_c),   mq_c ^ (mq_c >> 1));
`endif
   end

   // ---------------- directed stimulus ----------------
   int e_up[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   int e_dn[5]   = '{2, 1, 0, 9, 8};
   int e_bq[7]   = '{1, 0, 1, 0, 1, 0, 0};
   int e_btc[7]  = '{0, 1, 0, 1, 1, 1, 0};
   int e_gray[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
`ifdef T_COUNTER_GRAY_OUT_EN
   logic [3:0] g_prev;
`endif

   initial begin
      rst_a = 1'b1; en_a = 1'b0; up_a = 1'b1; ld_a = 1'b0; d_a = 4'd0;
      rst_b = 1'b1; en_b = 1'b0; up_b = 1'b1; ld_b = 1'b0; d_b = 3'd0;
      rst_c = 1'b1; en_c = 1'b0; up_c = 1'b1; ld_c = 1'b0; d_c = 4'd0;

      repeat (2) @(posedge clk);
      chk("rst_q",    int'(q_a),  0);
      chk("rst_tc",   int'(tc_a), 0);
      chk("rst_qbar", int'(qb_a), 15);
      chk("rst_tgl",  int'(tgl_a), 0);
      #1;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      en_a = 1'b1; up_a = 1'b1;

      // Count up 12 edges through the 9 -> 0 wrap.
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         chk("up_q",    int'(q_a),  e_up[i]);
         chk("up_tc",   int'(tc_a), (i == 9) ? 1 : 0);
         chk("up_qbar", int'(qb_a), 15 - e_up[i]);
      end

      // Load 3 then count down through the 0 -> 9 wrap.
      #1; ld_a = 1'b1; d_a = 4'd3;
      @(posedge clk);
      chk("ld3_q",  int'(q_a),  3);
      chk("ld3_tc", int'(tc_a), 0);
      #1; ld_a = 1'b0; up_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         chk("dn_q",  int'(q_a),  e_dn[i]);
         chk("dn_tc", int'(tc_a), (i == 3) ? 1 : 0);
         if (i == 2) chk("dn_tgl_at0", int'(tgl_a), 9);
      end

      // Clamped load, then wrap from the clamped value.
      #1; ld_a = 1'b1; d_a = 4'd14; en_a = 1'b0;
      @(posedge clk);
      chk("clamp_q",  int'(q_a),  9);
      chk("clamp_tc", int'(tc_a), 0);
      #1; ld_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
      @(posedge clk);
      chk("clwrap_q",  int'(q_a),  0);
      chk("clwrap_tc", int'(tc_a), 1);

      // Asynchronous reset while TC is high.
      #2; rst_a = 1'b1;
      #1;
      chk("arst_tc", int'(tc_a), 0);
      chk("arst_q",  int'(q_a),  0);
      #1; rst_a = 1'b0; ld_a = 1'b1; d_a = 4'd7; en_a = 1'b0;
      @(posedge clk);
      chk("ld7_q", int'(q_a), 7);

      // Asynchronous reset mid-period while Q=7; TGL gated even with EN=1.
      #1; ld_a = 1'b0; en_a = 1'b1;
      #1; rst_a = 1'b1;
      #1;
      chk("arst7_q",    int'(q_a),   0);
      chk("arst7_tc",   int'(tc_a),  0);
      chk("arst7_qbar", int'(qb_a),  15);
      chk("arst7_tgl",  int'(tgl_a), 0);
      @(posedge clk);
      #1; rst_a = 1'b0; en_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         chk("hold_q",   int'(q_a),   0);
         chk("hold_tgl", int'(tgl_a), 0);
      end

      // MODULUS=2: up wraps on alternate edges; alternating direction wraps every edge.
      #1; rst_b = 1'b1;
      #2; rst_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         chk("m2_q",  int'(q_b),  e_bq[i]);
         chk("m2_tc", int'(tc_b), e_btc[i]);
         #1;
         if (i == 3) up_b = 1'b0;
         else if (i == 4) up_b = 1'b1;
         else if (i == 5) en_b = 1'b0;
      end

      // Full-range counter: natural wrap 15 -> 0, Gray single-bit steps.
`ifdef T_COUNTER_GRAY_OUT_EN
      g_prev = 4'd0;
`endif
      en_c = 1'b1; up_c = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         chk("full_q",  int'(q_c),  (i == 15) ? 0 : i + 1);
         chk("full_tc", int'(tc_c), (i == 15) ? 1 : 0);
`ifdef T_COUNTER_GRAY_OUT_EN
         chk("gray_val",  int'(g_c), e_gray[i]);
         chk("gray_step", $countones(g_c ^ g_prev), 1);
         g_prev = g_c;
`else
         chk("gray_ref", (((i + 1) % 16) ^ (((i + 1) % 16) >> 1)), e_gray[i]);
`endif
      end
      #1; up_c = 1'b0;
      @(posedge clk);
      chk("full_dn_q",  int'(q_c),  15);
      chk("full_dn_tc", int'(tc_c), 1);
      #1; en_c = 1'b0;
      @(posedge clk);
      chk("full_hold_tc", int'(tc_c), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
